mmf_stream_sequencer: RTL and testbench

//  Upstream feeder for the ternary MAC neuron. Holds packed ternary weights and

---
 rtl/mmf_pkg.sv | 23 ++
 rtl/mmf_weight_regfile.sv | 49 ++++
 rtl/mmf_stream_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mmf_stream_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmf_pkg.sv
// Shared definitions for the ternary MAC neuron and its stream sequencer:
// weight encodings, sequencer state encoding and a weight classification helper.
package mmf_pkg;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b10;
    localparam logic [1:0] W_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        LAST,
        DONE
    } seq_state_t;

    // True when the weight contributes to the sum (+1 or -1).
    function automatic logic w_is_active(input logic [1:0] w);
        return (w == W_POS) || (w == W_NEG);
    endfunction

endpackage

// File: rtl/mmf_weight_regfile.sv
// Ternary weight store: DEPTH x 2 b flops, async-reset to W_ZERO.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   we           write strobe for one packed byte (4 entries)
//   waddr        first entry written; low two bits are always 0
//   wdata        entry waddr+0 in [1:0] ... entry waddr+3 in [7:6]
//   raddr        read index
//   rdata_c      combinational read data
module mmf_weight_regfile
    import mmf_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [1:0]    rdata_c
);

    logic [1:0] mem_q [DEPTH];
    logic [1:0] mem_d [DEPTH];

    // Packed write: the four entries of a byte share the upper address bits.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                mem_d[{waddr[AW-1:2], 2'(i)}] = wdata[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= W_ZERO;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/mmf_stream_sequencer.sv
// Upstream feeder for the ternary MAC neuron: stores packed ternary weights and
// streams one dot product per start command, pairing each activation beat with
// its stored weight. All outputs are registered.
// Optional feature macro: SEQ_ZERO_SKIP_EN -- zero/reserved-weight beats are
// consumed but presented to the MAC as bubbles (mac_valid=0, mac_act=0).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cfg_len, start, busy, done run control and status
//   wload_valid/data/ready     packed weight load stream (accepted in IDLE)
//   act_valid/data/ready       activation stream
//   mac_act/weight/valid/clear MAC drive pins
module mmf_stream_sequencer
    import mmf_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             wload_valid,
    input  logic [7:0]       wload_data,
    output logic             wload_ready,
    input  logic             act_valid,
    input  logic [7:0]       act_data,
    output logic             act_ready,
    output logic [7:0]       mac_act,
    output logic [1:0]       mac_weight,
    output logic             mac_valid,
    output logic             mac_clear
);

    localparam int unsigned AW = $clog2(DEPTH);

    seq_state_t       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wload_ready_q, wload_ready_d;
    logic             act_ready_q, act_ready_d;
    logic [7:0]       mac_act_q, mac_act_d;
    logic [1:0]       mac_weight_q, mac_weight_d;
    logic             mac_valid_q, mac_valid_d;
    logic             mac_clear_q, mac_clear_d;

    logic             wload_fire_c;
    logic             act_fire_c;
    logic             last_beat_c;
    logic [1:0]       weight_rd_c;
    logic [LEN_W-1:0] len_clamp_c;

    assign wload_fire_c = wload_valid && wload_ready_q;
    assign act_fire_c   = act_valid && act_ready_q;
    assign last_beat_c  = (LEN_W'(rptr_q) == (len_q - LEN_W'(1)));
    assign len_clamp_c  = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;

    mmf_weight_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wload_fire_c),
        .waddr   (wptr_q),
        .wdata   (wload_data),
        .raddr   (rptr_q),
        .rdata_c (weight_rd_c)
    );

    // Next state, counters and the values the output registers take next cycle.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        rptr_d       = rptr_q;
        wptr_d       = wptr_q;
        mac_act_d    = 8'h00;
        mac_weight_d = W_ZERO;
        mac_valid_d  = 1'b0;

        // wptr wraps modulo DEPTH, which need not be a power of two.
        if (wload_fire_c) begin
            wptr_d = (wptr_q == AW'(DEPTH - 4)) ? '0 : wptr_q + AW'(4);
        end

        case (state_q)
            IDLE: begin
                // A load beat in this cycle is still written at the old wptr.
                if (start) begin
                    len_d   = len_clamp_c;
                    rptr_d  = '0;
                    wptr_d  = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (len_q != '0) ? STREAM : DONE;
            end
            STREAM: begin
                if (act_fire_c) begin
`ifdef SEQ_ZERO_SKIP_EN
                    if (w_is_active(weight_rd_c)) begin
                        mac_valid_d  = 1'b1;
                        mac_act_d    = act_data;
                        mac_weight_d = weight_rd_c;
                    end
`else
                    mac_valid_d  = 1'b1;
                    mac_act_d    = act_data;
                    mac_weight_d = weight_rd_c;
`endif
                    rptr_d = rptr_q + AW'(1);
                    if (last_beat_c) begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d        = (state_d != IDLE);
        done_d        = (state_d == DONE);
        wload_ready_d = (state_d == IDLE);
        act_ready_d   = (state_d == STREAM);
        mac_clear_d   = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            len_q         <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wload_ready_q <= 1'b0;
            act_ready_q   <= 1'b0;
            mac_act_q     <= 8'h00;
            mac_weight_q  <= W_ZERO;
            mac_valid_q   <= 1'b0;
            mac_clear_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wload_ready_q <= wload_ready_d;
            act_ready_q   <= act_ready_d;
            mac_act_q     <= mac_act_d;
            mac_weight_q  <= mac_weight_d;
            mac_valid_q   <= mac_valid_d;
            mac_clear_q   <= mac_clear_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign wload_ready = wload_ready_q;
    assign act_ready   = act_ready_q;
    assign mac_act     = mac_act_q;
    assign mac_weight  = mac_weight_q;
    assign mac_valid   = mac_valid_q;
    assign mac_clear   = mac_clear_q;

endmodule

// File: tb/tb_mmf_stream_sequencer.sv
// Directed bench for mmf_stream_sequencer with a negedge monitor that records
// handshakes, MAC beats, clears, done pulses and a reference MAC accumulator.
module tb_mmf_stream_sequencer;
    import mmf_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned LEN_W = 7;
`ifdef SEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [LEN_W-1:0] cfg_len;
    logic             start;
    logic             busy;
    logic             done;
    logic             wload_valid;
    logic [7:0]       wload_data;
    logic             wload_ready;
    logic             act_valid;
    logic [7:0]       act_data;
    logic             act_ready;
    logic [7:0]       mac_act;
    logic [1:0]       mac_weight;
    logic             mac_valid;
    logic             mac_clear;

    mmf_stream_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_len     (cfg_len),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .wload_valid (wload_valid),
        .wload_data  (wload_data),
        .wload_ready (wload_ready),
        .act_valid   (act_valid),
        .act_data    (act_data),
        .act_ready   (act_ready),
        .mac_act     (mac_act),
        .mac_weight  (mac_weight),
        .mac_valid   (mac_valid),
        .mac_clear   (mac_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks;
    int n_fail;

    // Monitor state
    int         hs_cnt, last_hs_cyc, done_cnt, done_cyc, clr_cnt, clr_cyc;
    int         valid_cnt, bad_idle, acc, acc_at_done;
    logic [7:0] beat_act[$];
    logic [1:0] beat_w[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            acc = 0;
        end else begin
            if (act_valid && act_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if (mac_clear) begin
                clr_cnt++;
                clr_cyc = cyc;
                acc = 0;
            end
            if (mac_valid) begin
                valid_cnt++;
                beat_act.push_back(mac_act);
                beat_w.push_back(mac_weight);
                if (mac_weight == W_POS) acc = acc + int'($signed(mac_act));
                else if (mac_weight == W_NEG) acc = acc - int'($signed(mac_act));
            end else if (mac_act != 8'h00 || mac_weight != 2'b00) begin
                bad_idle++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                acc_at_done = acc;
            end
        end
    end

    // Stimulus tables, expected-beat model and snapshots
    logic [7:0] act_tab [128];
    logic [7:0] exp_act[$];
    logic [1:0] exp_wt[$];
    int         exp_acc;
    int         hs0, done0, clr0, valid0, beat0, bad0, s_cyc;

    function automatic logic [1:0] wsel(input logic [7:0] p, input int e);
        return p[2*(e%4) +: 2];
    endfunction

    // Expected MAC beats for n activations against entries loaded with byte pat.
    task automatic build_exp(input int n, input logic [7:0] pat);
        logic [1:0] w;
        exp_act.delete();
        exp_wt.delete();
        exp_acc = 0;
        for (int i = 0; i < n; i++) begin
            w = wsel(pat, i);
            if (!SKIP || w == W_POS || w == W_NEG) begin
                exp_act.push_back(act_tab[i]);
                exp_wt.push_back(w);
            end
            if (w == W_POS) exp_acc = exp_acc + int'($signed(act_tab[i]));
            else if (w == W_NEG) exp_acc = exp_acc - int'($signed(act_tab[i]));
        end
    endtask

    task automatic snap();
        hs0 = hs_cnt; done0 = done_cnt; clr0 = clr_cnt;
        valid0 = valid_cnt; beat0 = beat_act.size(); bad0 = bad_idle;
    endtask

    task automatic load_byte(input logic [7:0] b);
        int budget = 50;
        while (!wload_ready && budget > 0) begin
            @(posedge clk); #1; budget--;
        end
        if (budget == 0) begin
            n_checks++; n_fail++;
            $display("FAIL load_wait: wload_ready stayed 0, required 1");
        end
        wload_valid = 1'b1;
        wload_data  = b;
        @(posedge clk); #1;
        wload_valid = 1'b0;
        wload_data  = 8'h00;
    endtask

    task automatic start_run(input logic [LEN_W-1:0] len);
        cfg_len = len;
        start   = 1'b1;
        s_cyc   = cyc;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Feed act_tab until done, n_stop handshakes, or timeout. gap idles between
    // beats; start_at pulses a (to-be-ignored) start at that handshake index.
    task automatic drive_stream(input int n_stop, input int gap, input int start_at);
        int  idx = 0;
        int  budget = 2000;
        int  d0 = done_cnt;
        bit  fire;
        bit  pulsed = 1'b0;
        while (done_cnt == d0 && idx < n_stop && budget > 0) begin
            act_valid = 1'b1;
            act_data  = act_tab[idx];
            if (idx == start_at && !pulsed) begin
                start = 1'b1; cfg_len = LEN_W'(2); pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            fire = act_ready;
            @(posedge clk); #1;
            budget--;
            if (fire) begin
                idx++;
                if (gap > 0) begin
                    act_valid = 1'b0;
                    start = 1'b0;
                    repeat (gap) begin
                        @(posedge clk); #1; budget--;
                    end
                end
            end
        end
        act_valid = 1'b0;
        act_data  = 8'h00;
        start     = 1'b0;
        if (budget <= 0) begin
            n_checks++; n_fail++;
            $display("FAIL stream_timeout: run did not finish, handshakes=%0d", idx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({busy, done, wload_ready, act_ready, mac_act, mac_weight, mac_valid, mac_clear} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {busy, done, wload_ready, act_ready, mac_act, mac_weight, mac_valid, mac_clear});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (wload_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: wload_ready=%b busy=%b, required 1 0", wload_ready, busy);
        end
    endtask

    task automatic test_basic();
        act_tab[0] = 8'd10; act_tab[1] = 8'd20; act_tab[2] = 8'd30; act_tab[3] = 8'd40;
        load_byte(8'h11);
        snap();
        start_run(LEN_W'(4));
        drive_stream(127, 0, -1);
        build_exp(4, 8'h11);
        for (int i = 0; i < exp_act.size(); i++) begin
            n_checks++;
            if (beat0 + i >= beat_act.size()) begin
                n_fail++; $display("FAIL basic_beat%0d: missing, required (%0d,%b)", i, exp_act[i], exp_wt[i]);
            end else if (beat_act[beat0+i] !== exp_act[i] || beat_w[beat0+i] !== exp_wt[i]) begin
                n_fail++; $display("FAIL basic_beat%0d: got (%0d,%b), required (%0d,%b)", i,
                                   beat_act[beat0+i], beat_w[beat0+i], exp_act[i], exp_wt[i]);
            end
        end
        n_checks++;
        if (beat_act.size() - beat0 != exp_act.size()) begin
            n_fail++; $display("FAIL basic_nbeats: got %0d, required %0d", beat_act.size() - beat0, exp_act.size());
        end
        n_checks++;
        if (hs_cnt - hs0 != 4) begin
            n_fail++; $display("FAIL basic_hs: got %0d, required 4", hs_cnt - hs0);
        end
        n_checks++;
        if (clr_cnt - clr0 != 1 || clr_cyc != s_cyc + 1) begin
            n_fail++; $display("FAIL basic_clear: count %0d at +%0d, required 1 at +1", clr_cnt - clr0, clr_cyc - s_cyc);
        end
        n_checks++;
        if (last_hs_cyc != s_cyc + 5 || done_cyc != s_cyc + 7) begin
            n_fail++; $display("FAIL basic_timing: last hs +%0d done +%0d, required +5 +7",
                               last_hs_cyc - s_cyc, done_cyc - s_cyc);
        end
        n_checks++;
        if (done_cnt - done0 != 1 || acc_at_done != 40) begin
            n_fail++; $display("FAIL basic_result: dones %0d acc %0d, required 1 40", done_cnt - done0, acc_at_done);
        end
        n_checks++;
        if (bad_idle != bad0) begin
            n_fail++; $display("FAIL basic_idle_zero: %0d nonzero idle cycles, required 0", bad_idle - bad0);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) act_tab[i] = 8'(10 * (i + 1));
        load_byte(8'h11);
        load_byte(8'h11);
        snap();
        start_run(LEN_W'(8));
        drive_stream(127, 1, -1);
        build_exp(8, 8'h11);
        for (int i = 0; i < exp_act.size(); i++) begin
            n_checks++;
            if (beat0 + i >= beat_act.size()) begin
                n_fail++; $display("FAIL stall_beat%0d: missing, required (%0d,%b)", i, exp_act[i], exp_wt[i]);
            end else if (beat_act[beat0+i] !== exp_act[i] || beat_w[beat0+i] !== exp_wt[i]) begin
                n_fail++; $display("FAIL stall_beat%0d: got (%0d,%b), required (%0d,%b)", i,
                                   beat_act[beat0+i], beat_w[beat0+i], exp_act[i], exp_wt[i]);
            end
        end
        n_checks++;
        if (beat_act.size() - beat0 != exp_act.size() || hs_cnt - hs0 != 8) begin
            n_fail++; $display("FAIL stall_counts: beats %0d hs %0d, required %0d 8",
                               beat_act.size() - beat0, hs_cnt - hs0, exp_act.size());
        end
        n_checks++;
        if (done_cnt - done0 != 1 || done_cyc != last_hs_cyc + 2 || acc_at_done != 160) begin
            n_fail++; $display("FAIL stall_done: dones %0d lat %0d acc %0d, required 1 2 160",
                               done_cnt - done0, done_cyc - last_hs_cyc, acc_at_done);
        end
    endtask

    task automatic test_len_zero();
        snap();
        start_run(LEN_W'(0));
        drive_stream(127, 0, -1);
        n_checks++;
        if (clr_cnt - clr0 != 1 || clr_cyc != s_cyc + 1) begin
            n_fail++; $display("FAIL len0_clear: count %0d at +%0d, required 1 at +1", clr_cnt - clr0, clr_cyc - s_cyc);
        end
        n_checks++;
        if (done_cnt - done0 != 1 || done_cyc != s_cyc + 2) begin
            n_fail++; $display("FAIL len0_done: count %0d at +%0d, required 1 at +2", done_cnt - done0, done_cyc - s_cyc);
        end
        n_checks++;
        if (valid_cnt != valid0 || hs_cnt != hs0) begin
            n_fail++; $display("FAIL len0_quiet: valids %0d hs %0d, required 0 0", valid_cnt - valid0, hs_cnt - hs0);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) act_tab[i] = 8'(i + 1);
        load_byte(8'h11);
        load_byte(8'h11);
        start_run(LEN_W'(8));
        drive_stream(3, 0, -1);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({busy, done, wload_ready, act_ready, mac_act, mac_weight, mac_valid, mac_clear} !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h, required 0",
                     {busy, done, wload_ready, act_ready, mac_act, mac_weight, mac_valid, mac_clear});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (wload_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_idle: wload_ready=%b busy=%b, required 1 0", wload_ready, busy);
        end
        // Read the cleared store back through a run without loading.
        act_tab[0] = 8'd5; act_tab[1] = 8'd6; act_tab[2] = 8'd7; act_tab[3] = 8'd8;
        snap();
        start_run(LEN_W'(4));
        drive_stream(127, 0, -1);
        build_exp(4, 8'h00);
        for (int i = 0; i < exp_act.size(); i++) begin
            n_checks++;
            if (beat0 + i >= beat_act.size()) begin
                n_fail++; $display("FAIL midreset_beat%0d: missing, required (%0d,%b)", i, exp_act[i], exp_wt[i]);
            end else if (beat_act[beat0+i] !== exp_act[i] || beat_w[beat0+i] !== exp_wt[i]) begin
                n_fail++; $display("FAIL midreset_beat%0d: got (%0d,%b), required (%0d,%b)", i,
                                   beat_act[beat0+i], beat_w[beat0+i], exp_act[i], exp_wt[i]);
            end
        end
        n_checks++;
        if (beat_act.size() - beat0 != exp_act.size() || hs_cnt - hs0 != 4 || done_cnt - done0 != 1 || acc_at_done != 0) begin
            n_fail++; $display("FAIL midreset_run: beats %0d hs %0d dones %0d acc %0d, required %0d 4 1 0",
                               beat_act.size() - beat0, hs_cnt - hs0, done_cnt - done0, acc_at_done, exp_act.size());
        end
    endtask

    task automatic test_clamp();
        for (int i = 0; i < 128; i++) act_tab[i] = 8'(i + 1);
        repeat (16) load_byte(8'h61);
        snap();
        start_run(LEN_W'(100));
        drive_stream(127, 0, 10);
        build_exp(64, 8'h61);
        for (int i = 0; i < exp_act.size(); i++) begin
            n_checks++;
            if (beat0 + i >= beat_act.size()) begin
                n_fail++; $display("FAIL clamp_beat%0d: missing, required (%0d,%b)", i, exp_act[i], exp_wt[i]);
            end else if (beat_act[beat0+i] !== exp_act[i] || beat_w[beat0+i] !== exp_wt[i]) begin
                n_fail++; $display("FAIL clamp_beat%0d: got (%0d,%b), required (%0d,%b)", i,
                                   beat_act[beat0+i], beat_w[beat0+i], exp_act[i], exp_wt[i]);
            end
        end
        n_checks++;
        if (beat_act.size() - beat0 != exp_act.size() || hs_cnt - hs0 != 64) begin
            n_fail++; $display("FAIL clamp_counts: beats %0d hs %0d, required %0d 64",
                               beat_act.size() - beat0, hs_cnt - hs0, exp_act.size());
        end
        n_checks++;
        if (done_cnt - done0 != 1 || done_cyc != last_hs_cyc + 2 || acc_at_done != exp_acc) begin
            n_fail++; $display("FAIL clamp_done: dones %0d lat %0d acc %0d, required 1 2 %0d",
                               done_cnt - done0, done_cyc - last_hs_cyc, acc_at_done, exp_acc);
        end
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done_cnt - done0 != 1 || clr_cnt - clr0 != 1) begin
            n_fail++; $display("FAIL clamp_ignored_start: busy %b dones %0d clears %0d, required 0 1 1",
                               busy, done_cnt - done0, clr_cnt - clr0);
        end
    endtask

    initial begin
        cfg_len = '0; start = 1'b0;
        wload_valid = 1'b0; wload_data = 8'h00;
        act_valid = 1'b0; act_data = 8'h00;
        for (int i = 0; i < 128; i++) act_tab[i] = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_len_zero();
        test_reset_mid();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
